sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
// - N-client arbiter for the single SDRAMBus command port; successor to the hard-wired per-mode mux.
// - Clients raise read/write requests; a per-client enable mask replaces the single control_mode select.
// - Selects fixed-priority or round-robin; holds the grant until sdram_finished, then releases.
// - Watchdog aborts hung transactions.
// PARAMETERS
// N_CLI    5      number of clients (2..8)
// ADDR_W   23     SDRAM word address width
// DATA_W   32     SDRAM data width
// TIMEOUT  1024   cycles to wait for sdram_finished; 0 disables watchdog
// PORTS
// i_clk            in   1              system clock
// i_rst            in   1              async reset, active-high
// i_rr_mode        in   1              0 = fixed priority (lowest index wins), 1 = round-robin
// i_cli_en         in   N_CLI          client enable mask; disabled clients never granted
// i_cli_read       in   N_CLI          per-client read request (level, held until finished)
// i_cli_write      in   N_CLI          per-client write request (level, held until finished)
// i_cli_addr       in   N_CLI*ADDR_W   client i at [i*ADDR_W +: ADDR_W]
// i_cli_writedata  in   N_CLI*DATA_W   client i at [i*DATA_W +: DATA_W]
// o_cli_readdata   out  DATA_W         sdram_readdata broadcast to all clients
// o_cli_finished   out  N_CLI          one-hot completion pulse to granted client
// o_sdram_read     out  1              to SDRAMBus
// o_sdram_write    out  1              to SDRAMBus
// o_sdram_addr     out  ADDR_W         to SDRAMBus
// o_sdram_writedata out DATA_W         to SDRAMBus
// i_sdram_readdata in   DATA_W         from SDRAMBus
// i_sdram_finished in   1              from SDRAMBus, 1-cycle pulse
// o_busy           out  1              state != IDLE
// o_grant_idx      out  $clog2(N_CLI)  index of current/last grant
// o_conflict       out  1              1-cycle pulse: granted client had read and write both high
// o_timeout        out  1              sticky; set on watchdog abort, cleared only by i_rst
// BEHAVIOUR
// - Reset: state=IDLE; all sdram outputs 0; o_cli_finished=0; o_busy=0; o_grant_idx=0; o_conflict=0;
//   o_timeout=0; rr pointer=N_CLI-1 (client 0 first). Reset mid-transaction drops the command immediately.
// - Request r[i] = en[i] & (read[i] | write[i]).
// - States: IDLE -> BUSY -> RELEASE -> IDLE.
// - IDLE: if any r[i] at cycle t, latch winner g, addr, writedata and command.
//   - At t+1: state=BUSY, o_sdram_read or o_sdram_write high (registered).
//   - Fixed mode: lowest i with r[i]. RR mode: first r[i] searching ptr+1 .. ptr+N_CLI (mod N_CLI); ptr<=g on grant.
// - Read and write both high on winner: write issued, o_conflict pulses at t+1.
// - BUSY: command, addr, data held constant.
//   - Changes to i_cli_en / i_rr_mode / requests are ignored until IDLE.
//   - On i_sdram_finished: o_cli_finished[g]=1 same cycle (combinational, only in BUSY).
//   - Next cycle: sdram cmd=0, state=RELEASE.
// - RELEASE: exactly one cycle, no new grant, so the finished client can drop its request; then IDLE.
//   - Minimum back-to-back spacing: 3 cycles between command assertions.
// - o_cli_readdata = i_sdram_readdata (combinational); valid to client only while o_cli_finished[g].
// - Watchdog (TIMEOUT>0):
//   - Counter clears on entering BUSY and increments each BUSY cycle.
//   - Counter == TIMEOUT-1 with no finished: pulse o_cli_finished[g], set o_timeout, drop command, go to RELEASE.
//   - Finished arriving in the same cycle counts as normal completion; o_timeout is not set.
// - i_sdram_finished outside BUSY is ignored.
// - Requests from disabled clients stay pending, are never granted and are never flagged.
// TESTING
// - Fixed mode, en=5'b11111, clients 1 and 3 request read together -> client 1 granted (cmd at t+1), then client 3 after RELEASE.
// - RR mode, all 5 requesting continuously -> grant order 0,1,2,3,4,0; each finished pulse on matching bit only.
// - Client 2 write addr=0x12345 data=0xDEADBEEF, finished after 7 cycles -> o_sdram_write high 7 cycles, values held, o_cli_finished=5'b00100 once.
// - TIMEOUT=16, finished never arrives -> finished pulse at BUSY cycle 16, o_timeout=1 and stays 1 until i_rst.
// - Client 0 read+write both high -> write issued, o_conflict pulse; en cleared mid-BUSY -> transaction still completes.
// - i_rst asserted during BUSY -> all outputs 0 asynchronously; after release, first RR grant goes to client 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAMBus command port among N_CLI clients. Fixed priority
//   (lowest index wins) or round-robin selection. The grant is held until
//   i_sdram_finished, followed by one RELEASE cycle. An optional watchdog aborts
//   a transaction that never finishes.
// Ports
//   i_clk, i_rst            clock, async active-high reset
//   i_rr_mode, i_cli_en     arbitration mode, per-client enable mask
//   i_cli_read/_write       per-client level requests
//   i_cli_addr/_writedata   packed per-client address / write data
//   o_cli_readdata          SDRAM read data broadcast to all clients
//   o_cli_finished          one-hot completion pulse to the granted client
//   o_sdram_*, i_sdram_*    SDRAMBus command port
//   o_busy, o_grant_idx     status: not idle, current/last grant
//   o_conflict, o_timeout   read+write collision pulse, sticky watchdog flag
//
//   state   | meaning
//   IDLE    | no command; arbitrate and latch a winner
//   BUSY    | command driven, waiting for i_sdram_finished or watchdog
//   RELEASE | one idle cycle so the finished client can drop its request
module sdram_port_arbiter #(
    parameter int N_CLI   = 5,
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rr_mode,
    input  logic [N_CLI-1:0]          i_cli_en,
    input  logic [N_CLI-1:0]          i_cli_read,
    input  logic [N_CLI-1:0]          i_cli_write,
    input  logic [N_CLI*ADDR_W-1:0]   i_cli_addr,
    input  logic [N_CLI*DATA_W-1:0]   i_cli_writedata,
    output logic [DATA_W-1:0]         o_cli_readdata,
    output logic [N_CLI-1:0]          o_cli_finished,
    output logic                      o_sdram_read,
    output logic                      o_sdram_write,
    output logic [ADDR_W-1:0]         o_sdram_addr,
    output logic [DATA_W-1:0]         o_sdram_writedata,
    input  logic [DATA_W-1:0]         i_sdram_readdata,
    input  logic                      i_sdram_finished,
    output logic                      o_busy,
    output logic [$clog2(N_CLI)-1:0]  o_grant_idx,
    output logic                      o_conflict,
    output logic                      o_timeout
);
    localparam int IDX_W   = $clog2(N_CLI);
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic                conflict_q;
    logic                timeout_q;
    logic [WD_W-1:0]     wd_cnt_q;

    logic [N_CLI-1:0]    req;
    logic                found;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_rd;
    logic                sel_wr;
    logic                wd_hit;
    logic                fin_evt;

    always_comb begin
        req       = i_cli_en & (i_cli_read | i_cli_write);
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        // Round-robin scans ptr+1 .. ptr+N_CLI so the last winner goes last.
        for (int k = 0; k < N_CLI; k++) begin
            if (i_rr_mode)
                cand = IDX_W'((int'(ptr_q) + 1 + k) % N_CLI);
            else
                cand = IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int i = 0; i < N_CLI; i++) begin
            if (win == IDX_W'(i)) begin
                sel_addr  = i_cli_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = i_cli_writedata[i*DATA_W +: DATA_W];
                sel_rd    = i_cli_read[i];
                sel_wr    = i_cli_write[i];
            end
        end
    end

    assign wd_hit  = WD_EN && (wd_cnt_q == WD_W'(TO_LAST));
    assign fin_evt = (state_q == BUSY) && (i_sdram_finished || wd_hit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= IDX_W'(N_CLI - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
            timeout_q  <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            conflict_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q    <= win;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        // write wins when a client raises both
                        wr_q       <= sel_wr;
                        rd_q       <= sel_rd & ~sel_wr;
                        conflict_q <= sel_rd & sel_wr;
                        wd_cnt_q   <= '0;
                        if (i_rr_mode)
                            ptr_q <= win;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_sdram_finished || wd_hit) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= RELEASE;
                        if (!i_sdram_finished)
                            timeout_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cli_readdata    = i_sdram_readdata;
    assign o_cli_finished    = fin_evt ? (N_CLI'(1) << grant_q) : '0;
    assign o_sdram_read      = rd_q;
    assign o_sdram_write     = wr_q;
    assign o_sdram_addr      = addr_q;
    assign o_sdram_writedata = wdata_q;
    assign o_busy            = (state_q != IDLE);
    assign o_grant_idx       = grant_q;
    assign o_conflict        = conflict_q;
    assign o_timeout         = timeout_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed bench for sdram_port_arbiter with N_CLI=5, TIMEOUT=16.
module tb_sdram_port_arbiter;
    localparam int N  = 5;
    localparam int AW = 23;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            rr_mode;
    logic [N-1:0]    cli_en, cli_read, cli_write;
    logic [N*AW-1:0] cli_addr;
    logic [N*DW-1:0] cli_wdata;
    logic [DW-1:0]   cli_rdata;
    logic [N-1:0]    cli_fin;
    logic            sd_read, sd_write;
    logic [AW-1:0]   sd_addr;
    logic [DW-1:0]   sd_wdata, sd_rdata;
    logic            sd_fin;
    logic            busy;
    logic [2:0]      grant_idx;
    logic            conflict, timeout;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_arbiter #(.N_CLI(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_rr_mode(rr_mode), .i_cli_en(cli_en),
        .i_cli_read(cli_read), .i_cli_write(cli_write), .i_cli_addr(cli_addr),
        .i_cli_writedata(cli_wdata), .o_cli_readdata(cli_rdata), .o_cli_finished(cli_fin),
        .o_sdram_read(sd_read), .o_sdram_write(sd_write), .o_sdram_addr(sd_addr),
        .o_sdram_writedata(sd_wdata), .i_sdram_readdata(sd_rdata), .i_sdram_finished(sd_fin),
        .o_busy(busy), .o_grant_idx(grant_idx), .o_conflict(conflict), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse finished for one cycle, check the completion vector, end in RELEASE.
    task automatic do_finish(input string tag, input logic [N-1:0] exp_mask);
        sd_fin = 1'b1;
        #1;
        chk(tag, 64'(cli_fin), 64'(exp_mask));
        tick();
        sd_fin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rr_mode = 1'b0; cli_en = '0; cli_read = '0; cli_write = '0;
        sd_fin = 1'b0; sd_rdata = '0;
        for (int i = 0; i < N; i++) begin
            cli_addr[i*AW +: AW]  = AW'(32'h100 + i);
            cli_wdata[i*DW +: DW] = DW'(32'hA0 + i);
        end
        tick(); tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_read", 64'(sd_read), 0);
        chk("rst_write", 64'(sd_write), 0);
        chk("rst_addr", 64'(sd_addr), 0);
        chk("rst_wdata", 64'(sd_wdata), 0);
        chk("rst_grant", 64'(grant_idx), 0);
        chk("rst_conflict", 64'(conflict), 0);
        chk("rst_timeout", 64'(timeout), 0);
        chk("rst_fin", 64'(cli_fin), 0);
        rst = 1'b0;
        tick();

        // Fixed priority: clients 1 and 3 read together.
        cli_en = 5'b11111;
        cli_read = 5'b01010;
        tick();
        chk("fx_busy", 64'(busy), 1);
        chk("fx_grant1", 64'(grant_idx), 1);
        chk("fx_read1", 64'(sd_read), 1);
        chk("fx_addr1", 64'(sd_addr), 64'h101);
        sd_rdata = 32'hCAFEF00D;
        #1;
        chk("rdata_pass", 64'(cli_rdata), 64'hCAFEF00D);
        do_finish("fx_fin1", 5'b00010);
        cli_read[1] = 1'b0;
        chk("fx_rel_read", 64'(sd_read), 0);
        chk("fx_rel_busy", 64'(busy), 1);
        tick();
        chk("fx_idle_busy", 64'(busy), 0);
        chk("fx_idle_read", 64'(sd_read), 0);
        tick();
        chk("fx_grant3", 64'(grant_idx), 3);
        chk("fx_read3", 64'(sd_read), 1);
        chk("fx_addr3", 64'(sd_addr), 64'h103);
        do_finish("fx_fin3", 5'b01000);
        cli_read[3] = 1'b0;
        tick();

        // Round-robin, all clients requesting continuously.
        rr_mode = 1'b1;
        cli_read = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_grant", 64'(grant_idx), 64'(k % N));
            chk("rr_addr", 64'(sd_addr), 64'(32'h100 + (k % N)));
            do_finish("rr_fin", 5'(1 << (k % N)));
            tick();
        end
        cli_read = '0;
        tick();

        // Client 2 write, finished on BUSY cycle 7.
        cli_addr[2*AW +: AW]  = 23'h12345;
        cli_wdata[2*DW +: DW] = 32'hDEADBEEF;
        cli_write = 5'b00100;
        tick();
        for (int c = 1; c < 7; c++) begin
            chk("wr_write", 64'(sd_write), 1);
            chk("wr_read", 64'(sd_read), 0);
            chk("wr_addr", 64'(sd_addr), 64'h12345);
            chk("wr_data", 64'(sd_wdata), 64'hDEADBEEF);
            chk("wr_nofin", 64'(cli_fin), 0);
            tick();
        end
        chk("wr_write7", 64'(sd_write), 1);
        chk("wr_data7", 64'(sd_wdata), 64'hDEADBEEF);
        do_finish("wr_fin", 5'b00100);
        chk("wr_drop", 64'(sd_write), 0);
        chk("wr_fin_once", 64'(cli_fin), 0);
        cli_write = '0;
        tick();

        // Conflict on client 0; enable mask cleared mid-BUSY.
        rr_mode = 1'b0;
        cli_read = 5'b00001; cli_write = 5'b00001;
        tick();
        chk("cf_write", 64'(sd_write), 1);
        chk("cf_read", 64'(sd_read), 0);
        chk("cf_pulse", 64'(conflict), 1);
        tick();
        chk("cf_pulse_end", 64'(conflict), 0);
        cli_en = '0;
        tick();
        chk("cf_hold_busy", 64'(busy), 1);
        chk("cf_hold_write", 64'(sd_write), 1);
        do_finish("cf_fin", 5'b00001);
        cli_read = '0; cli_write = '0; cli_en = 5'b11111;
        tick();

        // Finished while idle is ignored.
        sd_fin = 1'b1;
        #1;
        chk("idle_fin", 64'(cli_fin), 0);
        tick();
        sd_fin = 1'b0;
        chk("idle_stay", 64'(busy), 0);

        // Disabled requester is never granted.
        cli_en = 5'b01111; cli_read = 5'b10000;
        tick(); tick();
        chk("dis_busy", 64'(busy), 0);
        cli_en = 5'b11111;

        // Watchdog: client 4 read, finished never comes.
        tick();
        chk("wd_grant", 64'(grant_idx), 4);
        for (int c = 1; c < 16; c++) begin
            chk("wd_nofin", 64'(cli_fin), 0);
            tick();
        end
        chk("wd_fin", 64'(cli_fin), 64'b10000);
        chk("wd_read16", 64'(sd_read), 1);
        chk("wd_tmo_pre", 64'(timeout), 0);
        tick();
        cli_read = '0;
        chk("wd_tmo", 64'(timeout), 1);
        chk("wd_drop", 64'(sd_read), 0);
        chk("wd_rel_fin", 64'(cli_fin), 0);
        tick(); tick();
        chk("wd_sticky", 64'(timeout), 1);

        // Reset during BUSY, then round-robin restarts at client 0.
        rr_mode = 1'b1;
        cli_write = 5'b01000;
        tick();
        chk("rb_write", 64'(sd_write), 1);
        chk("rb_grant", 64'(grant_idx), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 64'(busy), 0);
        chk("ar_write", 64'(sd_write), 0);
        chk("ar_addr", 64'(sd_addr), 0);
        chk("ar_wdata", 64'(sd_wdata), 0);
        chk("ar_grant", 64'(grant_idx), 0);
        chk("ar_timeout", 64'(timeout), 0);
        cli_write = '0;
        tick();
        rst = 1'b0;
        cli_read = 5'b11111;
        tick();
        chk("ar_rr_first", 64'(grant_idx), 0);
        chk("ar_rr_read", 64'(sd_read), 1);
        do_finish("ar_fin", 5'b00001);
        cli_read = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
